mem_arb: RTL and testbench
==========================

# mem_arb

Two-port DRAM request arbiter between the instruction cache and the data cache. It sits between the cache controllers and the single DRAM controller port. It accepts read requests from both caches and forwards at most one per cycle through a registered output stage. It tags each request with its source in the top xid bit, caps outstanding requests per source, and routes 128-bit fill responses back to the originating cache.

## Interface

Parameters:
- MAX_OUTST, 4 — maximum outstanding (issued, unanswered) requests per source; 1..4.
- STARVE_LIMIT, 4 — consecutive icache grants allowed while dcache waits (priority mode only).

Ports (reset is asynchronous, active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ic_mem_addr  in  [26:4]  icache line address
- ic_mem_xid  in  2  icache transaction id
- ic_mem_re  in  1  icache request valid
- mem_ic_ready  out  1  icache request accepted this cycle
- mem_ic_valid  out  1  icache fill valid
- mem_ic_xid  out  2  icache fill id
- mem_ic_data  out  128  icache fill data
- dc_mem_addr, dc_mem_xid, dc_mem_re  in  [26:4]/2/1  dcache request, same meaning as ic_*
- mem_dc_ready  out  1  dcache request accepted this cycle
- mem_dc_valid, mem_dc_xid, mem_dc_data  out  1/2/128  dcache fill
- arb_mem_addr  out  [26:4]  DRAM request address
- arb_mem_xid  out  3  {source, xid}; source 0 = icache, 1 = dcache
- arb_mem_re  out  1  DRAM request valid
- dram_arb_ready  in  1  DRAM accepts arb_mem_* this cycle
- dram_arb_valid  in  1  fill response valid
- dram_arb_xid  in  3  fill response id
- dram_arb_data  in  128  fill response data
- arb_err  out  1  sticky: response received for a source with zero outstanding

## Operation

- Request handshake: a transfer occurs in any cycle where re and ready are both high. A requester holds addr/xid/re stable until accepted.
- Output stage: one register (out_vld, addr, xid). A slot is free when out_vld is 0 or dram_arb_ready is 1. Both ready outputs are low when no slot is free; this is a combinational path from dram_arb_ready.
- Eligibility: a source is eligible when re is 1, its outstanding count is below MAX_OUTST, and a slot is free. mem_x_ready is 1 only for the granted source, so at most one source is ready per cycle.
- Arbitration (default, round-robin):
  - If only one source is eligible, it is granted.
  - If both are eligible, the source not granted last is granted.
  - The last-grant pointer updates only on a grant. It resets to dcache, so icache wins the first tie.
- Outstanding counters: 3-bit, one per source.
  - +1 on a grant to that source.
  - −1 on dram_arb_valid whose dram_arb_xid[2] selects that source.
  - Both in the same cycle: unchanged.
  - A response to a source whose count is 0 sets arb_err, and the counter stays at 0.
- Response routing:
  - dram_arb_xid[2] = 0 drives mem_ic_*; dram_arb_xid[2] = 1 drives mem_dc_*.
  - xid[1:0] and data pass through.
  - Responses cannot be back-pressured. The non-selected valid is 0.
- Reset (async assert, release synchronous to clk) clears every output, both counters, the output register, the pointer, the starve counter and arb_err. All outputs read 0 during reset.
- Reset mid-operation drops in-flight requests. Recovery is the caches' responsibility.

## Timing

- Grant in cycle T puts arb_mem_re=1 with the matching addr/xid in cycle T+1.
- arb_mem_re stays high until a cycle with dram_arb_ready=1. On the edge after that cycle, it drops or is replaced by the next grant. Back-to-back grants give one request per cycle.
- Response valid in cycle R gives mem_x_valid/xid/data registered in cycle R+1, as a single-cycle pulse.
- Count reaching MAX_OUTST at edge T deasserts that source's ready from cycle T+1. A response in cycle R re-enables it from cycle R+1.
- mem_x_ready may be high while DRAM stalls only if out_vld is 0.

## Configuration

- MEM_ARB_IC_PRIO_EN undefined: round-robin arbitration as above.
- MEM_ARB_IC_PRIO_EN defined: fixed priority to icache, using a starve counter.
  - The starve counter increments on each icache grant made while dcache is eligible.
  - When the count equals STARVE_LIMIT, the next tie goes to dcache.
  - The counter clears on any dcache grant, or when dcache is not requesting.

## Test plan

- Single icache request, addr 0x12345, xid 2, DRAM ready → arb_mem_re next cycle with xid 3'b010. A response with xid 3'b010 and data D → mem_ic_valid one cycle later with xid 2 and data D; mem_dc_valid stays 0.
- Both sources requesting continuously, DRAM always ready, round-robin → grants alternate ic, dc, ic, dc, with the first grant to icache.
- dram_arb_ready held 0 for 5 cycles with one request pending → arb_mem_* held stable and both readys 0. The request is released on the first ready cycle.
- Icache issues 4 requests with no responses, MAX_OUTST=4 → mem_ic_ready stays 0 while dcache is still granted. One icache response → icache is granted again the cycle after.
- Response xid 3'b100 with dcache count 0 → arb_err=1, stays set until reset, mem_dc_valid still pulses. Async rst_n low mid-burst → all outputs 0 immediately.
- MEM_ARB_IC_PRIO_EN defined, STARVE_LIMIT=4, both requesting → grant pattern ic×4, dc, ic×4, dc.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: two-port DRAM read-request arbiter between icache and dcache.
// Forwards at most one request per cycle through a registered output stage,
// tags it with its source in xid[2], caps outstanding requests per source,
// and routes 128-bit fill responses back to the originating cache.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ic_mem_addr/xid/re, mem_ic_ready  icache request handshake
//   mem_ic_valid/xid/data             icache fill (registered pulse)
//   dc_mem_addr/xid/re, mem_dc_ready  dcache request handshake
//   mem_dc_valid/xid/data             dcache fill (registered pulse)
//   arb_mem_addr/xid/re, dram_arb_ready  DRAM request port
//   dram_arb_valid/xid/data           DRAM fill response
//   arb_err                           sticky: response with zero outstanding
//
// Build option: define MEM_ARB_IC_PRIO_EN for fixed icache priority with a
// starvation limit instead of round-robin.

module mem_arb #(
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [26:4]   ic_mem_addr,
    input  logic [1:0]    ic_mem_xid,
    input  logic          ic_mem_re,
    output logic          mem_ic_ready,
    output logic          mem_ic_valid,
    output logic [1:0]    mem_ic_xid,
    output logic [127:0]  mem_ic_data,
    input  logic [26:4]   dc_mem_addr,
    input  logic [1:0]    dc_mem_xid,
    input  logic          dc_mem_re,
    output logic          mem_dc_ready,
    output logic          mem_dc_valid,
    output logic [1:0]    mem_dc_xid,
    output logic [127:0]  mem_dc_data,
    output logic [26:4]   arb_mem_addr,
    output logic [2:0]    arb_mem_xid,
    output logic          arb_mem_re,
    input  logic          dram_arb_ready,
    input  logic          dram_arb_valid,
    input  logic [2:0]    dram_arb_xid,
    input  logic [127:0]  dram_arb_data,
    output logic          arb_err
);

    localparam logic [2:0] MAX_C = 3'(MAX_OUTST);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

    logic          out_vld;
    logic [26:4]   out_addr;
    logic [2:0]    out_xid;
    logic [2:0]    ic_cnt;
    logic [2:0]    dc_cnt;
    logic          last_dc;
    logic [SW-1:0] starve;

    logic slot_free;
    logic ic_elig;
    logic dc_elig;
    logic tie_dc;
    logic gnt_ic;
    logic gnt_dc;
    logic rsp_ic;
    logic rsp_dc;

    // A bogus response (count already 0) must not swallow a real grant
    // made in the same cycle, hence 0 -> 1 in the both-active case.
    function automatic logic [2:0] cnt_next(
        input logic [2:0] c,
        input logic       inc,
        input logic       dec
    );
        logic [2:0] n;
        n = c;
        unique case ({inc, dec})
            2'b10:   n = c + 3'd1;
            2'b01:   n = (c == 3'd0) ? 3'd0 : c - 3'd1;
            2'b11:   n = (c == 3'd0) ? 3'd1 : c;
            default: n = c;
        endcase
        return n;
    endfunction

    always_comb begin
        slot_free = !out_vld || dram_arb_ready;
        // rst_n gating keeps the ready outputs low while reset is held.
        ic_elig   = rst_n && ic_mem_re && (ic_cnt < MAX_C) && slot_free;
        dc_elig   = rst_n && dc_mem_re && (dc_cnt < MAX_C) && slot_free;
`ifdef MEM_ARB_IC_PRIO_EN
        tie_dc    = (starve == STARVE_C);
`else
        tie_dc    = !last_dc;
`endif
        gnt_ic    = ic_elig && !(dc_elig && tie_dc);
        gnt_dc    = dc_elig && !gnt_ic;
        rsp_ic    = dram_arb_valid && !dram_arb_xid[2];
        rsp_dc    = dram_arb_valid && dram_arb_xid[2];
    end

    assign mem_ic_ready = gnt_ic;
    assign mem_dc_ready = gnt_dc;
    assign arb_mem_re   = out_vld;
    assign arb_mem_addr = out_addr;
    assign arb_mem_xid  = out_xid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld      <= 1'b0;
            out_addr     <= '0;
            out_xid      <= '0;
            ic_cnt       <= '0;
            dc_cnt       <= '0;
            last_dc      <= 1'b1;
            starve       <= '0;
            arb_err      <= 1'b0;
            mem_ic_valid <= 1'b0;
            mem_ic_xid   <= '0;
            mem_ic_data  <= '0;
            mem_dc_valid <= 1'b0;
            mem_dc_xid   <= '0;
            mem_dc_data  <= '0;
        end else begin
            unique case (1'b1)
                gnt_ic: begin
                    out_vld  <= 1'b1;
                    out_addr <= ic_mem_addr;
                    out_xid  <= {1'b0, ic_mem_xid};
                end
                gnt_dc: begin
                    out_vld  <= 1'b1;
                    out_addr <= dc_mem_addr;
                    out_xid  <= {1'b1, dc_mem_xid};
                end
                default: begin
                    if (dram_arb_ready) out_vld <= 1'b0;
                end
            endcase

            if (gnt_ic)      last_dc <= 1'b0;
            else if (gnt_dc) last_dc <= 1'b1;

            // Counts icache wins taken while dcache was also eligible.
            if (gnt_dc || !dc_mem_re)
                starve <= '0;
            else if (gnt_ic && dc_elig && starve != STARVE_C)
                starve <= starve + 1'b1;

            ic_cnt <= cnt_next(ic_cnt, gnt_ic, rsp_ic);
            dc_cnt <= cnt_next(dc_cnt, gnt_dc, rsp_dc);

            if ((rsp_ic && ic_cnt == 3'd0) || (rsp_dc && dc_cnt == 3'd0))
                arb_err <= 1'b1;

            mem_ic_valid <= rsp_ic;
            mem_dc_valid <= rsp_dc;
            if (rsp_ic) begin
                mem_ic_xid  <= dram_arb_xid[1:0];
                mem_ic_data <= dram_arb_data;
            end
            if (rsp_dc) begin
                mem_dc_xid  <= dram_arb_xid[1:0];
                mem_dc_data <= dram_arb_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: scoreboard of DRAM requests and fills,
// plus directed checks of arbitration, stall, cap, error and reset.

module tb_mem_arb;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [26:4]   ic_mem_addr;
    logic [1:0]    ic_mem_xid;
    logic          ic_mem_re;
    logic          mem_ic_ready;
    logic          mem_ic_valid;
    logic [1:0]    mem_ic_xid;
    logic [127:0]  mem_ic_data;
    logic [26:4]   dc_mem_addr;
    logic [1:0]    dc_mem_xid;
    logic          dc_mem_re;
    logic          mem_dc_ready;
    logic          mem_dc_valid;
    logic [1:0]    mem_dc_xid;
    logic [127:0]  mem_dc_data;
    logic [26:4]   arb_mem_addr;
    logic [2:0]    arb_mem_xid;
    logic          arb_mem_re;
    logic          dram_arb_ready;
    logic          dram_arb_valid;
    logic [2:0]    dram_arb_xid;
    logic [127:0]  dram_arb_data;
    logic          arb_err;

    logic          auto_rsp;
    logic          mr_vld;
    logic [2:0]    mr_xid;
    logic [127:0]  mr_data;
    logic          ar_vld;
    logic [2:0]    ar_xid;
    logic [127:0]  ar_data;

    assign dram_arb_valid = auto_rsp ? ar_vld  : mr_vld;
    assign dram_arb_xid   = auto_rsp ? ar_xid  : mr_xid;
    assign dram_arb_data  = auto_rsp ? ar_data : mr_data;

    mem_arb #(.MAX_OUTST(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_mem_addr(ic_mem_addr), .ic_mem_xid(ic_mem_xid),
        .ic_mem_re(ic_mem_re), .mem_ic_ready(mem_ic_ready),
        .mem_ic_valid(mem_ic_valid), .mem_ic_xid(mem_ic_xid),
        .mem_ic_data(mem_ic_data),
        .dc_mem_addr(dc_mem_addr), .dc_mem_xid(dc_mem_xid),
        .dc_mem_re(dc_mem_re), .mem_dc_ready(mem_dc_ready),
        .mem_dc_valid(mem_dc_valid), .mem_dc_xid(mem_dc_xid),
        .mem_dc_data(mem_dc_data),
        .arb_mem_addr(arb_mem_addr), .arb_mem_xid(arb_mem_xid),
        .arb_mem_re(arb_mem_re), .dram_arb_ready(dram_arb_ready),
        .dram_arb_valid(dram_arb_valid), .dram_arb_xid(dram_arb_xid),
        .dram_arb_data(dram_arb_data), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [159:0] got,
                         input logic [159:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct packed {
        logic         dc;
        logic         ic;
        logic [1:0]   xid;
        logic [127:0] data;
    } rsp_t;

    logic [25:0] req_q[$];
    rsp_t        rsp_q[$];
    logic        gnt_log[$];
    logic        exp_vld = 1'b0;
    logic        rsp_due = 1'b0;

    // Scoreboard monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        logic [25:0] e;
        rsp_t        r;
        logic        gi;
        logic        gd;
        if (!rst_n) begin
            req_q.delete();
            rsp_q.delete();
            gnt_log.delete();
            exp_vld = 1'b0;
            rsp_due = 1'b0;
        end else begin
            check("arb_re", arb_mem_re, exp_vld);
            check("one_rdy", mem_ic_ready & mem_dc_ready, 0);
            if (exp_vld && !dram_arb_ready)
                check("stall_rdy", {mem_ic_ready, mem_dc_ready}, 0);
            if (arb_mem_re && dram_arb_ready) begin
                if (req_q.size() == 0) begin
                    check("req_unexp", arb_mem_re, 0);
                end else begin
                    e = req_q.pop_front();
                    check("req", {arb_mem_xid, arb_mem_addr}, e);
                end
            end
            if (rsp_due) begin
                r = rsp_q.pop_front();
                if (r.dc)
                    check("rsp_dc", {mem_dc_valid, mem_ic_valid,
                                     mem_dc_xid, mem_dc_data}, r);
                else
                    check("rsp_ic", {mem_dc_valid, mem_ic_valid,
                                     mem_ic_xid, mem_ic_data}, r);
            end else begin
                check("rsp_idle", {mem_ic_valid, mem_dc_valid}, 0);
            end
            rsp_due = dram_arb_valid;
            if (dram_arb_valid)
                rsp_q.push_back({dram_arb_xid[2], !dram_arb_xid[2],
                                 dram_arb_xid[1:0], dram_arb_data});
            gi = ic_mem_re && mem_ic_ready;
            gd = dc_mem_re && mem_dc_ready;
            if (gi) begin
                req_q.push_back({1'b0, ic_mem_xid, ic_mem_addr});
                gnt_log.push_back(1'b0);
            end
            if (gd) begin
                req_q.push_back({1'b1, dc_mem_xid, dc_mem_addr});
                gnt_log.push_back(1'b1);
            end
            if (gi || gd)          exp_vld = 1'b1;
            else if (dram_arb_ready) exp_vld = 1'b0;
        end
    end

    // DRAM model: answers each accepted request in the following cycle.
    logic       acc = 1'b0;
    logic [2:0] acc_xid = 3'd0;
    always @(negedge clk) begin
        acc     = rst_n && arb_mem_re && dram_arb_ready;
        acc_xid = arb_mem_xid;
    end
    always @(posedge clk) begin
        #1;
        ar_vld  = acc;
        ar_xid  = acc_xid;
        ar_data = {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {mem_ic_ready, mem_dc_ready, mem_ic_valid, mem_dc_valid,
                    arb_mem_re, arb_err, mem_ic_xid, mem_dc_xid,
                    arb_mem_xid, arb_mem_addr}, 0);
        check({tag, "_icd"}, mem_ic_data, 0);
        check({tag, "_dcd"}, mem_dc_data, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ic_mem_re = 1'b0;
        dc_mem_re = 1'b0;
        mr_vld = 1'b0;
        auto_rsp = 1'b0;
        dram_arb_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        tick();
        rst_n = 1'b1;
    endtask

    // Requester model: each cache keeps re high until n requests are taken.
    task automatic drive(input int n_ic, input int n_dc);
        int   li;
        int   ld;
        int   cyc;
        logic gi;
        logic gd;
        li = n_ic;
        ld = n_dc;
        cyc = 0;
        ic_mem_addr = 23'($urandom);
        ic_mem_xid  = 2'($urandom);
        dc_mem_addr = 23'($urandom);
        dc_mem_xid  = 2'($urandom);
        ic_mem_re = (li > 0);
        dc_mem_re = (ld > 0);
        while ((li > 0 || ld > 0) && cyc < 200) begin
            @(negedge clk);
            gi = ic_mem_re && mem_ic_ready;
            gd = dc_mem_re && mem_dc_ready;
            tick();
            cyc++;
            if (gi) begin
                li--;
                ic_mem_addr = 23'($urandom);
                ic_mem_xid  = 2'($urandom);
            end
            if (gd) begin
                ld--;
                dc_mem_addr = 23'($urandom);
                dc_mem_xid  = 2'($urandom);
            end
            ic_mem_re = (li > 0);
            dc_mem_re = (ld > 0);
        end
        check("drv_done", (li == 0 && ld == 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] pat;
        int          n;
        logic        g_ic;
        ic_mem_addr = '0;
        ic_mem_xid  = '0;
        dc_mem_addr = '0;
        dc_mem_xid  = '0;
        mr_xid  = '0;
        mr_data = '0;
        do_reset();

        // Single icache request and fill.
        ic_mem_addr = 23'h12345;
        ic_mem_xid  = 2'd2;
        ic_mem_re   = 1'b1;
        @(negedge clk);
        check("b_rdy", {mem_ic_ready, mem_dc_ready}, 2'b10);
        tick();
        ic_mem_re = 1'b0;
        @(negedge clk);
        check("b_req", {arb_mem_re, arb_mem_xid, arb_mem_addr},
              {1'b1, 3'b010, 23'h12345});
        tick();
        mr_vld  = 1'b1;
        mr_xid  = 3'b010;
        mr_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        tick();
        mr_vld = 1'b0;
        @(negedge clk);
        check("b_fill", {mem_ic_valid, mem_dc_valid, mem_ic_xid, mem_ic_data},
              {1'b1, 1'b0, 2'd2, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210});
        @(negedge clk);
        check("b_pulse", mem_ic_valid, 0);
        tick();

        // DRAM stall with a pending request and both caches asking.
        drive(1, 0);
        dram_arb_ready = 1'b0;
        ic_mem_re = 1'b1;
        dc_mem_re = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("d_hold", {arb_mem_re, mem_ic_ready, mem_dc_ready}, 3'b100);
            tick();
        end
        dram_arb_ready = 1'b1;
        @(negedge clk);
        check("d_rel", {mem_ic_ready, mem_dc_ready}, 2'b01);
        g_ic = mem_ic_ready;
        tick();
        if (g_ic) ic_mem_re = 1'b0;
        else      dc_mem_re = 1'b0;
        @(negedge clk);
        check("d_2nd", {mem_ic_ready, mem_dc_ready}, 2'b10);
        tick();
        ic_mem_re = 1'b0;
        dc_mem_re = 1'b0;
        repeat (2) tick();

        // Arbitration pattern with both caches requesting.
        do_reset();
        auto_rsp = 1'b1;
`ifdef MEM_ARB_IC_PRIO_EN
        drive(8, 2);
        pat = 16'b0000_0010_0001_0000;
        n = 10;
`else
        drive(4, 4);
        pat = 16'b0000_0000_1010_1010;
        n = 8;
`endif
        check("gnt_n", gnt_log.size(), n);
        for (int i = 0; i < n && i < gnt_log.size(); i++)
            check($sformatf("gnt_%0d", i), gnt_log[i], pat[i]);
        repeat (4) tick();

        // Outstanding cap on icache.
        do_reset();
        drive(4, 0);
        ic_mem_re = 1'b1;
        dc_mem_re = 1'b1;
        @(negedge clk);
        check("cap_rdy", {mem_ic_ready, mem_dc_ready}, 2'b01);
        tick();
        dc_mem_re = 1'b0;
        @(negedge clk);
        check("cap_ic", mem_ic_ready, 0);
        tick();
        mr_vld  = 1'b1;
        mr_xid  = 3'b001;
        mr_data = {4{32'hcafe_f00d}};
        @(negedge clk);
        check("cap_same", mem_ic_ready, 0);
        tick();
        mr_vld = 1'b0;
        @(negedge clk);
        check("cap_regrant", mem_ic_ready, 1);
        tick();
        ic_mem_re = 1'b0;
        repeat (2) tick();

        // Response with zero outstanding, then reset mid-burst.
        do_reset();
        mr_vld  = 1'b1;
        mr_xid  = 3'b100;
        mr_data = {4{32'h5a5a_a5a5}};
        tick();
        mr_vld = 1'b0;
        @(negedge clk);
        check("err_set", {arb_err, mem_dc_valid, mem_ic_valid}, 3'b110);
        repeat (3) tick();
        @(negedge clk);
        check("err_sticky", arb_err, 1);
        tick();
        auto_rsp  = 1'b1;
        ic_mem_re = 1'b1;
        dc_mem_re = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        ic_mem_re = 1'b0;
        dc_mem_re = 1'b0;
        auto_rsp  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
